// File: rtl/core_pkg.sv
// Shared definitions for the core data port: FSM states, default widths and
// the local-region address decode.
package core_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } port_state_t;

  // An address is local when every bit above the scratchpad index is zero.
  function automatic logic is_local(input logic [63:0] addr, input int unsigned lmem_w);
    return (addr >> lmem_w) == 64'd0;
  endfunction

endpackage

// File: rtl/core_data_port_if.sv
// Remote shared-bus signals between the data port (master) and the bus (slave).
interface core_data_port_if
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] remote_addr;
  logic                  remote_wren;
  logic                  remote_rden;
  logic [DATA_WIDTH-1:0] remote_write_val;
  logic                  remote_ready;
  logic [DATA_WIDTH-1:0] remote_read_val;

  modport master (
    output remote_addr, remote_wren, remote_rden, remote_write_val,
    input  remote_ready, remote_read_val
  );

  modport slave (
    input  remote_addr, remote_wren, remote_rden, remote_write_val,
    output remote_ready, remote_read_val
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a peek at the entry behind the head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign second  = mem[rd_ptr + PW'(1)];
  assign count   = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_data_port.sv
// Pipeline data-port front end: routes accesses to the local scratchpad or the
// remote bus, posting remote stores through a write buffer.
module core_data_port
  import core_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int LMEM_ADDR_WIDTH = 11,
  parameter int WB_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       daddr,
  input  logic                        dwrite_en,
  input  logic                        dread_en,
  input  logic [DATA_WIDTH-1:0]       ddata_out,
  output logic [DATA_WIDTH-1:0]       ddata_in,
  output logic                        stall,
  output logic                        bus_error,
  output logic [LMEM_ADDR_WIDTH-1:0]  lmem_addr,
  output logic                        lmem_we,
  output logic [DATA_WIDTH-1:0]       lmem_wdata,
  input  logic [DATA_WIDTH-1:0]       lmem_q,
  core_data_port_if.master            bus,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  port_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wval_q, wval_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  lat_en;
  logic [DATA_WIDTH-1:0] lat_val;

  logic                  is_loc, wr_remote, rd_pend, rd_acc, ld_loc_acc;
  logic                  push, pop, fifo_full, fifo_empty, waiting, tmo;
  logic [EW-1:0]         head, second, next_head;
  logic [CW-1:0]         count;

  logic                  sel_lmem_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;

  assign is_loc     = is_local(64'(daddr), LMEM_ADDR_WIDTH);
  assign wr_remote  = dwrite_en & ~is_loc;
  assign rd_pend    = dread_en & ~dwrite_en & ~is_loc;
  assign push       = wr_remote & ~fifo_full;
  assign rd_acc     = rd_pend & (state_q == ST_RESP);
  assign ld_loc_acc = dread_en & ~dwrite_en & is_loc;
  assign stall      = (wr_remote & fifo_full) | (rd_pend & (state_q != ST_RESP));

  assign lmem_addr  = daddr[LMEM_ADDR_WIDTH-1:0];
  assign lmem_we    = dwrite_en & is_loc;
  assign lmem_wdata = ddata_out;

  // With one entry left, the follow-on write can only be the store arriving now.
  assign next_head = (count > CW'(1)) ? second : {daddr, ddata_out};

  assign waiting = ((state_q == ST_WRITE) || (state_q == ST_READ)) && !bus.remote_ready;
  assign tmo     = (TIMEOUT_CYCLES != 0) && waiting && (tcnt_q == TLIM);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (WB_DEPTH)
  ) u_wb (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .din    ({daddr, ddata_out}),
    .pop    (pop),
    .head   (head),
    .second (second),
    .count  (count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    wren_d  = wren_q;
    rden_d  = rden_q;
    addr_d  = addr_q;
    wval_d  = wval_q;
    tcnt_d  = tcnt_q;
    pop     = 1'b0;
    err_d   = 1'b0;
    lat_en  = 1'b0;
    lat_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d          = ST_WRITE;
          wren_d           = 1'b1;
          {addr_d, wval_d} = head;
        end else if (rd_pend) begin
          state_d = ST_READ;
          rden_d  = 1'b1;
          addr_d  = daddr;
        end
      end
      ST_WRITE: begin
        if (bus.remote_ready || tmo) begin
          pop    = 1'b1;
          err_d  = tmo;
          tcnt_d = '0;
          if ((count > CW'(1)) || push) begin
            {addr_d, wval_d} = next_head;
          end else if (rd_pend) begin
            state_d = ST_READ;
            wren_d  = 1'b0;
            rden_d  = 1'b1;
            addr_d  = daddr;
          end else begin
            state_d = ST_IDLE;
            wren_d  = 1'b0;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_READ: begin
        if (bus.remote_ready || tmo) begin
          lat_en  = 1'b1;
          lat_val = bus.remote_ready ? bus.remote_read_val : '0;
          err_d   = tmo;
          state_d = ST_RESP;
          rden_d  = 1'b0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and remote-bus register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      wval_q  <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Load-return stage: select between scratchpad output and latched remote data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_lmem_p1 <= 1'b0;
      rdata_p1    <= '0;
    end else begin
      if (ld_loc_acc)  sel_lmem_p1 <= 1'b1;
      else if (rd_acc) sel_lmem_p1 <= 1'b0;
      if (lat_en) rdata_p1 <= lat_val;
    end
  end

  assign ddata_in             = sel_lmem_p1 ? lmem_q : rdata_p1;
  assign bus_error            = err_q;
  assign wb_count             = count;
  assign bus.remote_addr      = addr_q;
  assign bus.remote_wren      = wren_q;
  assign bus.remote_rden      = rden_q;
  assign bus.remote_write_val = wval_q;

endmodule

// File: tb/tb_core_data_port.sv
// Bench for core_data_port: local vector table, posted writes, ordering,
// timeout, reset mid-write and a wide/narrow-region instance.
module tb_core_data_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] daddr, ddata_out, ddata_in, lmem_wdata, lmem_q;
  logic        dwrite_en, dread_en, stall, bus_error, lmem_we;
  logic [10:0] lmem_addr;
  logic [2:0]  wb_count;

  logic [15:0] daddr2;
  logic [31:0] ddata_out2, ddata_in2, lmem_wdata2, lmem_q2;
  logic        dwrite2, dread2, stall2, bus_error2, lmem_we2;
  logic [7:0]  lmem_addr2;
  logic [2:0]  wb_count2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ram     [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [15:0] rq[$];
  logic [31:0] wq[$];

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] data;
    logic        we_exp;
  } vec_t;
  vec_t vecs[7];

  core_data_port_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();
  core_data_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus2 ();

  core_data_port #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .LMEM_ADDR_WIDTH(11), .WB_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwrite_en(dwrite_en), .dread_en(dread_en),
    .ddata_out(ddata_out), .ddata_in(ddata_in), .stall(stall), .bus_error(bus_error),
    .lmem_addr(lmem_addr), .lmem_we(lmem_we), .lmem_wdata(lmem_wdata), .lmem_q(lmem_q),
    .bus(bus.master), .wb_count(wb_count)
  );

  core_data_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .LMEM_ADDR_WIDTH(8), .WB_DEPTH(4), .TIMEOUT_CYCLES(255)
  ) dut2 (
    .clk(clk), .reset(reset), .daddr(daddr2), .dwrite_en(dwrite2), .dread_en(dread2),
    .ddata_out(ddata_out2), .ddata_in(ddata_in2), .stall(stall2), .bus_error(bus_error2),
    .lmem_addr(lmem_addr2), .lmem_we(lmem_we2), .lmem_wdata(lmem_wdata2), .lmem_q(lmem_q2),
    .bus(bus2.master), .wb_count(wb_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lmem_we) ram[lmem_addr] <= lmem_wdata;
    lmem_q <= ram[lmem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [15:0] e;
    if (rq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got load data %0h, expected none queued", name, ddata_in);
    end else begin
      e = rq.pop_front();
      check(name, ddata_in, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dwrite_en = 1'b0;
    dread_en  = 1'b0;
    daddr     = '0;
    ddata_out = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        pop_due, acc, acc_now, done, saw_rd;
    int          cyc, n_wr, stall_cnt, rd_cyc, err_cyc, act;
    logic [31:0] e32;

    vecs[0] = '{16'h0010, 1'b1, 16'hBEEF, 1'b1};
    vecs[1] = '{16'h0010, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{16'h07FF, 1'b1, 16'h1357, 1'b1};
    vecs[3] = '{16'h0000, 1'b1, 16'hA5A5, 1'b1};
    vecs[4] = '{16'h07FF, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h0010, 1'b0, 16'h0000, 1'b0};

    reset = 1'b1;
    idle_inputs();
    daddr2 = '0; dwrite2 = 1'b0; dread2 = 1'b0; ddata_out2 = '0; lmem_q2 = '0;
    bus.remote_ready = 1'b0;  bus.remote_read_val = '0;
    bus2.remote_ready = 1'b0; bus2.remote_read_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wren", bus.remote_wren, 0);
    check("rst_rden", bus.remote_rden, 0);
    check("rst_addr", bus.remote_addr, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_wb_count", wb_count, 0);
    check("rst_ddata_in", ddata_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Local load/store vectors
    pop_due = 1'b0;
    for (int i = 0; i < 7; i++) begin
      daddr = vecs[i].addr; dwrite_en = vecs[i].wr; dread_en = !vecs[i].wr;
      ddata_out = vecs[i].data;
      @(negedge clk);
      if (pop_due) sb_pop("t1_load_data");
      check("t1_stall", stall, 0);
      check("t1_lmem_we", lmem_we, vecs[i].we_exp);
      if (vecs[i].wr) ref_mem[vecs[i].addr[10:0]] = vecs[i].data;
      else rq.push_back(ref_mem[vecs[i].addr[10:0]]);
      pop_due = !vecs[i].wr;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    if (pop_due) sb_pop("t1_load_data");
    tick();

    // Posted writes: fill the buffer with ready low, fifth store must stall
    bus.remote_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      daddr = 16'h8000 + 16'(i); ddata_out = 16'hC000 + 16'(i);
      dwrite_en = 1'b1; dread_en = 1'b0;
      @(negedge clk);
      check("t2_store_stall", stall, 0);
      wq.push_back({daddr, ddata_out});
      tick();
    end
    daddr = 16'h8004; ddata_out = 16'hC004;
    @(negedge clk);
    check("t2_wb_full_count", wb_count, 4);
    check("t2_fifth_stall", stall, 1);
    tick();
    bus.remote_ready = 1'b1;
    acc = 1'b0; n_wr = 0; cyc = 0;
    while (cyc < 30 && !(acc && wq.size() == 0)) begin
      cyc++;
      @(negedge clk);
      acc_now = 1'b0;
      if (dwrite_en && !stall) begin
        wq.push_back({daddr, ddata_out});
        acc = 1'b1;
        acc_now = 1'b1;
      end
      if (bus.remote_wren && bus.remote_ready) begin
        e32 = wq.pop_front();
        check("t2_write_order", {bus.remote_addr, bus.remote_write_val}, e32);
        n_wr++;
      end
      tick();
      if (acc_now) dwrite_en = 1'b0;
    end
    check("t2_fifth_accepted", acc, 1);
    check("t2_writes_seen", n_wr, 5);
    check("t2_back_to_back_cycles", cyc, 5);
    @(negedge clk);
    check("t2_wren_idle", bus.remote_wren, 0);
    check("t2_wb_empty", wb_count, 0);
    tick();

    // Ordering: two buffered writes drain before the remote load is issued
    bus.remote_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      daddr = 16'h8010 + 16'(i); ddata_out = 16'h0A0A + 16'(i);
      dwrite_en = 1'b1; dread_en = 1'b0;
      tick();
      wq.push_back({daddr, ddata_out});
    end
    dwrite_en = 1'b0; dread_en = 1'b1; daddr = 16'h9000;
    bus.remote_ready = 1'b1; bus.remote_read_val = 16'h1234;
    done = 1'b0; saw_rd = 1'b0; stall_cnt = 0; cyc = 0;
    while (cyc < 30 && !done) begin
      cyc++;
      @(negedge clk);
      acc_now = 1'b0;
      if (bus.remote_rden && !saw_rd) begin
        saw_rd = 1'b1;
        check("t3_writes_before_read", wq.size(), 0);
        check("t3_read_addr", bus.remote_addr, 16'h9000);
      end
      if (bus.remote_wren && bus.remote_ready) begin
        e32 = wq.pop_front();
        check("t3_write_order", {bus.remote_addr, bus.remote_write_val}, e32);
      end
      if (dread_en && !stall) begin
        rq.push_back(16'h1234);
        acc_now = 1'b1;
      end else if (dread_en) begin
        stall_cnt++;
      end
      tick();
      if (acc_now) begin
        idle_inputs();
        @(negedge clk);
        sb_pop("t3_read_data");
        done = 1'b1;
        tick();
      end
    end
    check("t3_read_done", done, 1);
    check("t3_read_issued", saw_rd, 1);
    check("t3_min_stall", (stall_cnt >= 2), 1);

    // Timeout on a remote load with ready held low
    bus.remote_ready = 1'b0; bus.remote_read_val = 16'h5555;
    dread_en = 1'b1; dwrite_en = 1'b0; daddr = 16'hA000;
    done = 1'b0; rd_cyc = 0; err_cyc = 0; cyc = 0;
    while (cyc < 40 && !done) begin
      cyc++;
      @(negedge clk);
      acc_now = 1'b0;
      if (bus.remote_rden) rd_cyc++;
      if (bus_error) err_cyc++;
      if (dread_en && !stall) begin
        rq.push_back(16'h0000);
        acc_now = 1'b1;
      end
      tick();
      if (acc_now) begin
        idle_inputs();
        @(negedge clk);
        sb_pop("t4_timeout_data");
        check("t4_error_cleared", bus_error, 0);
        done = 1'b1;
        tick();
      end
    end
    check("t4_load_done", done, 1);
    check("t4_wait_cycles", rd_cyc, 8);
    check("t4_error_pulses", err_cyc, 1);
    daddr = 16'h0010; dread_en = 1'b1;
    @(negedge clk);
    check("t4_no_stall_after", stall, 0);
    rq.push_back(ref_mem[11'h010]);
    tick();
    idle_inputs();
    @(negedge clk);
    sb_pop("t4_local_after");
    tick();

    // Reset while a buffered write is on the bus
    bus.remote_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      daddr = 16'h8020 + 16'(i); ddata_out = 16'h7000 + 16'(i);
      dwrite_en = 1'b1;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("t5_wren_before", bus.remote_wren, 1);
    check("t5_count_before", wb_count, 3);
    #2 reset = 1'b1;
    #1;
    check("t5_wren_async", bus.remote_wren, 0);
    check("t5_count_async", wb_count, 0);
    check("t5_rden_async", bus.remote_rden, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.remote_ready = 1'b1;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.remote_wren || bus.remote_rden) act++;
      tick();
    end
    check("t5_no_activity", act, 0);

    // Narrow local region on a 32-bit instance
    daddr2 = 16'h00FF; dwrite2 = 1'b1; ddata_out2 = 32'hDEADBEEF;
    @(negedge clk);
    check("t6_local_we", lmem_we2, 1);
    check("t6_local_addr", lmem_addr2, 8'hFF);
    check("t6_local_wdata", lmem_wdata2, 32'hDEADBEEF);
    check("t6_local_stall", stall2, 0);
    tick();
    daddr2 = 16'h0100;
    @(negedge clk);
    check("t6_remote_we", lmem_we2, 0);
    check("t6_remote_stall", stall2, 0);
    tick();
    dwrite2 = 1'b0;
    @(negedge clk);
    check("t6_remote_enqueued", wb_count2, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_data_port.md
Name: core_data_port

Overview:
- Data-port front end placed between the pipeline data interface and the core's two memory paths: local scratchpad (dual-port RAM, data port) and the shared remote bus.
- Generalises the current fixed-width direct routing:
  - parametrised data, address and local-memory widths;
  - posted write buffer, so remote stores do not stall the pipeline;
  - registered remote-bus outputs;
  - bus-timeout error reporting.

Parameters:
- DATA_WIDTH, 16, data path width.
- ADDR_WIDTH, 16, pipeline data address width.
- LMEM_ADDR_WIDTH, 11, local memory address bits. Local region is addresses below 2**LMEM_ADDR_WIDTH.
- WB_DEPTH, 4, posted write buffer entries. Power of two, ≥2.
- TIMEOUT_CYCLES, 255, maximum wait for remote_ready. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- daddr  in  ADDR_WIDTH  pipeline data address
- dwrite_en  in  1  pipeline store request
- dread_en  in  1  pipeline load request
- ddata_out  in  DATA_WIDTH  store data
- ddata_in  out  DATA_WIDTH  load data, valid the cycle after acceptance
- stall  out  1  combinational; request is not accepted this cycle
- bus_error  out  1  one-cycle pulse on remote timeout
- lmem_addr  out  LMEM_ADDR_WIDTH  local RAM data-port address
- lmem_we  out  1  local RAM write enable
- lmem_wdata  out  DATA_WIDTH  local RAM write data
- lmem_q  in  DATA_WIDTH  local RAM read data, 1-cycle latency
- remote_addr  out  ADDR_WIDTH  registered
- remote_wren  out  1  registered
- remote_rden  out  1  registered
- remote_write_val  out  DATA_WIDTH  registered
- remote_ready  in  1  completes the current remote transaction
- remote_read_val  in  DATA_WIDTH  valid when remote_ready=1 with remote_rden=1
- wb_count  out  $clog2(WB_DEPTH)+1  write buffer occupancy

Behaviour:
- **Reset values.** All outputs 0: remote_* outputs, bus_error, wb_count, ddata_in. State is IDLE, buffer empty, timeout counter 0. Reset mid-transaction deasserts remote_wren/remote_rden immediately and discards all buffered writes.
- **Acceptance and select.**
  - A request (dread_en or dwrite_en) is accepted at a rising edge where stall=0.
  - The pipeline holds daddr, ddata_out and the enables stable while stall=1.
  - local = daddr[ADDR_WIDTH-1:LMEM_ADDR_WIDTH]==0.
- **Local access.**
  - Never stalls.
  - lmem_addr = daddr low bits; lmem_we = dwrite_en & local; lmem_wdata = ddata_out.
  - A registered select chooses lmem_q for ddata_in in the following cycle.
- **Remote store.**
  - stall=1 while wb_count==WB_DEPTH.
  - Otherwise accepted and enqueued {daddr, ddata_out}; wb_count increments next cycle.
  - A simultaneous enqueue and dequeue leaves wb_count unchanged.
- **Remote load.**
  - stall=1 until the buffer is empty and the read has completed. Buffered writes always drain before a load is issued (program order).
  - Sequence:
    1. In IDLE with wb_count==0, go to READ. remote_rden=1 and remote_addr=daddr from the next cycle.
    2. On the edge where remote_ready=1, latch remote_read_val and go to RESP.
    3. In RESP, stall=0, so the load is accepted. ddata_in = latched data in the next cycle. State returns to IDLE.
  - Minimum remote-load stall is 2 cycles.
- **State machine (IDLE, WRITE, READ, RESP).**
  - IDLE → WRITE when the buffer is non-empty. The head entry is loaded into remote_addr/remote_write_val and remote_wren=1.
  - WRITE: outputs are held until remote_ready=1. Then the entry is dequeued and the next state is:
    - WRITE if more entries remain;
    - READ if the buffer is empty and a remote load is pending;
    - otherwise IDLE.
  - READ as described under Remote load.
- **Timeout.**
  - The counter counts cycles in WRITE/READ with remote_ready=0.
  - When it reaches TIMEOUT_CYCLES, the transaction is aborted. Remote enables drop and bus_error pulses for 1 cycle.
  - An aborted WRITE dequeues and discards its entry.
  - An aborted READ goes to RESP with data 0.
  - The counter clears whenever a transaction completes or is aborted.
- **Simultaneous requests.** dread_en and dwrite_en both high is illegal: the store takes priority and the load is ignored.
- **Remote bus protocol.** remote_rden and remote_wren are never both 1. Remote addr/data are stable while either enable is high.

Decomposition:
- Shared package core_pkg holds:
  - port FSM state typedef (IDLE, WRITE, READ, RESP);
  - local-region decode helper function;
  - default width constants (DATA_WIDTH=16, ADDR_WIDTH=16).
- Sub-module sync_fifo (parametrised width/depth, count output) implements the posted write buffer, with width ADDR_WIDTH+DATA_WIDTH.

Test Plan:
1. **Local load/store.** Store 0xBEEF to 0x0010, then load 0x0010 → stall never asserted; ddata_in=0xBEEF the cycle after load acceptance.
2. **Posted writes.** Four remote stores to 0x8000–0x8003, remote_ready=0 → no stall for stores 1–4; wb_count=4; 5th store stalls. Raise ready → writes appear in order, 1 per ready cycle, and the 5th is accepted.
3. **Ordering.** Two buffered writes, then a remote load of 0x9000 with ready=1 and read_val=0x1234 → remote_rden rises only after both writes complete; ddata_in=0x1234.
4. **Timeout.** TIMEOUT_CYCLES=8, remote load with ready held 0 → bus_error pulses once after 8 waiting cycles; ddata_in=0; no stall afterward.
5. **Reset mid-WRITE.** Assert reset while remote_wren=1 with wb_count=3 → remote_wren=0 asynchronously; wb_count=0; after release no bus activity.
6. **Parameter sweep.** DATA_WIDTH=32, LMEM_ADDR_WIDTH=8 → address 0x0100 routes remote; 0x00FF routes local.
